xeng_vacc: RTL and testbench



---
 rtl/xeng_pkg.sv | 68 ++++++
 rtl/bram_sdp_behave.sv | 38 +++
 rtl/xeng_vacc.sv | 177 +++++++++++++++++
 tb/tb_xeng_vacc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xeng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xeng_pkg
//  Description : Shared X-engine widths, log2 helper, sign-extend and
//                saturate helpers used by the tap chain and accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package xeng_pkg;

    localparam int c_num_lanes = 8;
    localparam int c_calc_w    = 64;

    typedef logic signed [c_calc_w-1:0] calc_t;
    typedef logic signed [c_calc_w:0]   wide_sum_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int log2_func(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int lane_in_func(input int bitwidth, input int p_bits, input int s_bits);
        return 2 * bitwidth + 1 + p_bits + s_bits;
    endfunction

    function automatic int acc_width_func(input int bitwidth, input int p_bits, input int s_bits);
        return c_num_lanes * lane_in_func(bitwidth, p_bits, s_bits);
    endfunction

    // Treat the low `width` bits of value as a signed number and extend it.
    function automatic calc_t sext_func(input logic [c_calc_w-1:0] value, input int width);
        calc_t t;
        t = $signed(value << (c_calc_w - width));
        return t >>> (c_calc_w - width);
    endfunction

    function automatic wide_sum_t sat_func(input wide_sum_t sum, input int width);
        wide_sum_t max_v;
        wide_sum_t min_v;
        wide_sum_t res;
        max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
        min_v = -(65'sd1 <<< (width - 1));
        if (sum > max_v) begin
            res = max_v;
        end else if (sum < min_v) begin
            res = min_v;
        end else begin
            res = sum;
        end
        return res;
    endfunction

    function automatic logic sat_hit_func(input wide_sum_t sum, input int width);
        wide_sum_t max_v;
        wide_sum_t min_v;
        max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
        min_v = -(65'sd1 <<< (width - 1));
        return (sum > max_v) || (sum < min_v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_sdp_behave.sv
`default_nettype none
// ============================================================================
//  Module      : bram_sdp_behave
//  Description : Behavioural simple-dual-port RAM, registered address and
//                registered data on the read side (2-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_sdp_behave #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        r_rd_addr <= i_rd_addr;
        r_rd_data <= r_mem[r_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/xeng_vacc.sv
`default_nettype none
// ============================================================================
//  Module      : xeng_vacc
//  Description : Long-term vector accumulator behind the last X-engine tap;
//                integrates 8 signed lanes over ACC_LEN vectors and dumps.
//  Revision    : 1.0 - initial release
// ============================================================================
module xeng_vacc
    import xeng_pkg::*;
#(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int P_FACTOR_BITS       = 0,
    parameter int BITWIDTH            = 4,
    parameter int VEC_LEN_BITS        = 5,
    parameter int ACC_LEN             = 16,
    parameter int OUT_WIDTH           = 32
) (
    input  logic                                                              clk,
    input  logic                                                              rst,
    input  logic                                                              sync_in,
    input  logic [acc_width_func(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS)-1:0] acc_in,
    input  logic                                                              valid_in,
    output logic [8*OUT_WIDTH-1:0]                                            dout,
    output logic                                                              dout_valid,
    output logic [VEC_LEN_BITS-1:0]                                           dout_addr,
    output logic                                                              dout_last,
    output logic                                                              sync_out,
    output logic                                                              ovf
);

    localparam int c_lane_in   = lane_in_func(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS);
    localparam int c_acc_width = acc_width_func(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS);
    localparam int c_dout_w    = c_num_lanes * OUT_WIDTH;
    localparam int c_vidx_w    = (ACC_LEN > 1) ? log2_func(ACC_LEN) : 1;

    // ------------------------------------------------------------------
    // Word / vector counters; sync forces the current word to (0,0)
    // ------------------------------------------------------------------
    logic [VEC_LEN_BITS-1:0] r_widx;
    logic [c_vidx_w-1:0]     r_vidx;
    logic [VEC_LEN_BITS-1:0] w_widx;
    logic [c_vidx_w-1:0]     w_vidx;
    logic                    w_first;
    logic                    w_last;

    always_comb begin
        w_widx  = sync_in ? '0 : r_widx;
        w_vidx  = sync_in ? '0 : r_vidx;
        w_first = (w_vidx == '0);
        w_last  = (w_vidx == c_vidx_w'(ACC_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_widx <= '0;
            r_vidx <= '0;
        end else if (valid_in) begin
            r_widx <= w_widx + 1'b1;
            if (w_widx == '1) begin
                r_vidx <= w_last ? '0 : w_vidx + 1'b1;
            end else begin
                r_vidx <= w_vidx;
            end
        end else if (sync_in) begin
            r_widx <= '0;
            r_vidx <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stages aligned with the 2-cycle RAM read
    // ------------------------------------------------------------------
    logic                    r_s1_valid;
    logic                    r_s1_first;
    logic                    r_s1_last;
    logic [VEC_LEN_BITS-1:0] r_s1_addr;
    logic [c_acc_width-1:0]  r_s1_data;
    logic                    r_s2_valid;
    logic                    r_s2_first;
    logic                    r_s2_last;
    logic [VEC_LEN_BITS-1:0] r_s2_addr;
    logic [c_acc_width-1:0]  r_s2_data;
    logic [2:0]              r_sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_sync_d   <= '0;
        end else begin
            r_s1_valid <= valid_in;
            r_s2_valid <= r_s1_valid;
            r_sync_d   <= {r_sync_d[1:0], sync_in};
        end
    end

    always_ff @(posedge clk) begin
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_addr  <= w_widx;
        r_s1_data  <= acc_in;
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_addr  <= r_s1_addr;
        r_s2_data  <= r_s1_data;
    end

    // ------------------------------------------------------------------
    // Accumulator RAM and per-lane saturating adders
    // ------------------------------------------------------------------
    logic                    r_wr_en;
    logic [VEC_LEN_BITS-1:0] r_wr_addr;
    logic [c_dout_w-1:0]     r_new;
    logic [c_dout_w-1:0]     w_rd_data;
    logic [c_dout_w-1:0]     w_new;
    logic [c_num_lanes-1:0]  w_clamp;

    bram_sdp_behave #(
        .ADDR_WIDTH (VEC_LEN_BITS),
        .DATA_WIDTH (c_dout_w)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (r_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (r_new),
        .i_rd_addr (w_widx),
        .o_rd_data (w_rd_data)
    );

    for (genvar k = 0; k < c_num_lanes; k++) begin : g_lane
        calc_t     w_in_ext;
        calc_t     w_ram_ext;
        wide_sum_t w_sum;

        assign w_in_ext  = sext_func(c_calc_w'(r_s2_data[k*c_lane_in +: c_lane_in]), c_lane_in);
        assign w_ram_ext = sext_func(c_calc_w'(w_rd_data[k*OUT_WIDTH +: OUT_WIDTH]), OUT_WIDTH);
        assign w_sum     = {w_ram_ext[c_calc_w-1], w_ram_ext} + {w_in_ext[c_calc_w-1], w_in_ext};

        // The first vector of an integration overwrites whatever is stored.
        assign w_new[k*OUT_WIDTH +: OUT_WIDTH] = r_s2_first ? OUT_WIDTH'(w_in_ext)
                                                            : OUT_WIDTH'(sat_func(w_sum, OUT_WIDTH));
        assign w_clamp[k] = ~r_s2_first & sat_hit_func(w_sum, OUT_WIDTH);
    end

    logic r_dout_valid;
    logic r_dout_last;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_new        <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_wr_en      <= r_s2_valid;
            r_dout_valid <= r_s2_valid & r_s2_last;
            r_dout_last  <= r_s2_valid & r_s2_last & (r_s2_addr == '1);
            if (r_s2_valid) begin
                r_wr_addr <= r_s2_addr;
                r_new     <= w_new;
            end
            r_ovf <= (r_ovf & ~sync_in) | (r_s2_valid & (|w_clamp));
        end
    end

    assign dout       = r_new;
    assign dout_valid = r_dout_valid;
    assign dout_addr  = r_wr_addr;
    assign dout_last  = r_dout_last;
    assign sync_out   = r_sync_d[2];
    assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_xeng_vacc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xeng_vacc
//  Description : Directed self-checking bench for xeng_vacc (three configs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xeng_vacc;

    typedef struct packed {
        logic             v;
        logic             last;
        logic [1:0]       addr;
        logic             sync;
        logic [7:0][31:0] lanes;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sync_in;
    logic         valid_in;
    logic [127:0] acc_in;

    logic [255:0] dout_a, dout_b;
    logic [135:0] dout_c;
    logic         dv_a, dv_b, dv_c;
    logic [1:0]   da_a, da_b, da_c;
    logic         dl_a, dl_b, dl_c;
    logic         so_a, so_b, so_c;
    logic         ov_a, ov_b, ov_c;

    logic [7:0][31:0] sel_dout;
    logic             sel_valid, sel_last, sel_sync, sel_ovf;
    logic [1:0]       sel_addr;

    int   sel;
    int   n_tests;
    int   n_fail;
    exp_t e_d1, e_d2;
    exp_t e_tmp;
    int   n_valid;

    always #5 clk = ~clk;

    xeng_vacc #(.VEC_LEN_BITS(2), .ACC_LEN(3), .OUT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .sync_in(sync_in), .acc_in(acc_in), .valid_in(valid_in),
        .dout(dout_a), .dout_valid(dv_a), .dout_addr(da_a), .dout_last(dl_a),
        .sync_out(so_a), .ovf(ov_a));

    xeng_vacc #(.VEC_LEN_BITS(2), .ACC_LEN(16), .OUT_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .sync_in(sync_in), .acc_in(acc_in), .valid_in(valid_in),
        .dout(dout_b), .dout_valid(dv_b), .dout_addr(da_b), .dout_last(dl_b),
        .sync_out(so_b), .ovf(ov_b));

    xeng_vacc #(.VEC_LEN_BITS(2), .ACC_LEN(4), .OUT_WIDTH(17)) dut_c (
        .clk(clk), .rst(rst), .sync_in(sync_in), .acc_in(acc_in), .valid_in(valid_in),
        .dout(dout_c), .dout_valid(dv_c), .dout_addr(da_c), .dout_last(dl_c),
        .sync_out(so_c), .ovf(ov_c));

    always_comb begin
        sel_dout  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_sync  = 1'b0;
        sel_ovf   = 1'b0;
        sel_addr  = '0;
        case (sel)
            0: begin
                sel_dout = dout_a; sel_valid = dv_a; sel_last = dl_a;
                sel_sync = so_a;   sel_ovf   = ov_a; sel_addr = da_a;
            end
            1: begin
                sel_dout = dout_b; sel_valid = dv_b; sel_last = dl_b;
                sel_sync = so_b;   sel_ovf   = ov_b; sel_addr = da_b;
            end
            default: begin
                for (int k = 0; k < 8; k++) begin
                    sel_dout[k] = {{15{dout_c[k*17+16]}}, dout_c[k*17 +: 17]};
                end
                sel_valid = dv_c; sel_last = dl_c;
                sel_sync  = so_c; sel_ovf  = ov_c; sel_addr = da_c;
            end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] fill(input logic [15:0] x);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[k*16 +: 16] = x;
        return r;
    endfunction

    function automatic exp_t exp_all(input int addr, input logic last, input logic [31:0] val);
        exp_t e;
        e = '0;
        e.v    = 1'b1;
        e.last = last;
        e.addr = addr[1:0];
        for (int k = 0; k < 8; k++) e.lanes[k] = val;
        return e;
    endfunction

    // Drive one cycle, then compare outputs against the word driven two steps
    // earlier (three-cycle latency as seen one tick after the edge).
    task automatic step(input logic v, input logic s, input logic [127:0] d, input exp_t e);
        valid_in = v;
        sync_in  = s;
        acc_in   = d;
        @(posedge clk);
        #1;
        check("dout_valid", 64'(sel_valid), 64'(e_d2.v));
        check("dout_last",  64'(sel_last),  64'(e_d2.last));
        check("sync_out",   64'(sel_sync),  64'(e_d2.sync));
        if (e_d2.v) begin
            check("dout_addr", 64'(sel_addr), 64'(e_d2.addr));
            for (int k = 0; k < 8; k++) begin
                check($sformatf("dout_lane%0d", k), 64'(sel_dout[k]), 64'(e_d2.lanes[k]));
            end
        end
        e_d2 = e_d1;
        e_d1 = e;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        valid_in = 1'b0;
        sync_in  = 1'b0;
        acc_in   = '0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_dout_zero", 64'(|sel_dout), 64'd0);
        check("rst_dout_valid", 64'(sel_valid), 64'd0);
        check("rst_dout_addr", 64'(sel_addr), 64'd0);
        check("rst_dout_last", 64'(sel_last), 64'd0);
        check("rst_sync_out", 64'(sel_sync), 64'd0);
        check("rst_ovf", 64'(sel_ovf), 64'd0);
        rst  = 1'b0;
        e_d1 = '0;
        e_d2 = '0;
    endtask

    task automatic flush();
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sel     = 0;
        e_d1    = '0;
        e_d2    = '0;
        rst     = 1'b1;

        // Continuous stream, all lanes +5, 3 vectors of 4 words -> 15
        do_reset(3);
        for (int i = 0; i < 12; i++)
            step(1'b1, 1'b0, fill(16'd5), (i >= 8) ? exp_all(i - 8, i == 11, 32'd15) : exp_t'('0));
        flush();

        // Gapped stream 1/0/0/1, garbage data on idle cycles
        n_valid = 0;
        for (int c = 0; c < 24; c++) begin
            if ((c % 4 == 0) || (c % 4 == 3)) begin
                step(1'b1, 1'b0, fill(16'd5),
                     (n_valid >= 8) ? exp_all(n_valid - 8, n_valid == 11, 32'd15) : exp_t'('0));
                n_valid++;
            end else begin
                step(1'b0, 1'b0, fill(16'd9), '0);
            end
        end
        flush();

        // Lane ordering / sign extension, ACC_LEN=16
        sel = 1;
        do_reset(2);
        for (int i = 0; i < 64; i++) begin
            e_tmp = '0;
            if (i >= 60) begin
                e_tmp.v        = 1'b1;
                e_tmp.addr     = 2'(i - 60);
                e_tmp.last     = (i == 63);
                e_tmp.lanes[0] = 32'hFFFF_FFF0;
                e_tmp.lanes[7] = 32'd524272;
            end
            step(1'b1, 1'b0, {16'h7FFF, 96'd0, 16'hFFFF}, e_tmp);
        end
        flush();

        // Saturation with OUT_WIDTH=17, then sync clears ovf
        sel = 2;
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, fill(16'h7FFF), (i >= 12) ? exp_all(i - 12, i == 15, 32'd65535) : exp_t'('0));
            if (i == 9)  check("ovf_before_clamp", 64'(sel_ovf), 64'd0);
            if (i == 10) check("ovf_on_clamp", 64'(sel_ovf), 64'd1);
        end
        flush();
        check("ovf_sticky", 64'(sel_ovf), 64'd1);
        e_tmp = '0;
        e_tmp.sync = 1'b1;
        step(1'b0, 1'b1, '0, e_tmp);
        check("ovf_cleared", 64'(sel_ovf), 64'd0);
        flush();

        // Sync mid-integration (vector 1, word 2) with valid
        sel = 0;
        do_reset(2);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, fill(16'd5), '0);
        for (int j = 0; j < 12; j++) begin
            e_tmp = (j >= 8) ? exp_all(j - 8, j == 11, 32'd21) : exp_t'('0);
            e_tmp.sync = (j == 0);
            step(1'b1, j == 0, fill(16'd7), e_tmp);
        end
        flush();

        // Reset in the middle of a dump
        do_reset(2);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, fill(16'd5), (i >= 8) ? exp_all(i - 8, 1'b0, 32'd15) : exp_t'('0));
        step(1'b0, 1'b0, '0, '0);
        do_reset(1);
        for (int i = 0; i < 12; i++)
            step(1'b1, 1'b0, fill(16'd3), (i >= 8) ? exp_all(i - 8, i == 11, 32'd9) : exp_t'('0));
        flush();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
